// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline hazard inputs and the stall/flush control outputs of
//   hazard_ctrl_unit.
//   slave  : the hazard controller (reads hazard info, drives controls)
//   master : the pipeline / environment (drives hazard info, reads controls)
//   Hazard info : id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
//                 if_id_use_rs1, if_id_use_rs2, branch_taken, imem_ready,
//                 mul_start, mul_done
//   Controls    : pc_write, if_id_write, if_id_flush, id_ex_write,
//                 id_ex_flush, ex_mem_flush, stall, mul_timeout
interface hazard_ctrl_if;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_use_rs1;
  logic       if_id_use_rs2;
  logic       branch_taken;
  logic       imem_ready;
  logic       mul_start;
  logic       mul_done;

  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       stall;
  logic       mul_timeout;

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
           if_id_use_rs1, if_id_use_rs2, branch_taken, imem_ready,
           mul_start, mul_done,
    output pc_write, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_flush, stall, mul_timeout
  );

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
           if_id_use_rs1, if_id_use_rs2, branch_taken, imem_ready,
           mul_start, mul_done,
    input  pc_write, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_flush, stall, mul_timeout
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Stall / flush controller for the 5-stage RISC-V pipeline. Resolves
//   load-use hazards, taken-branch flushes, fetch wait states and
//   multi-cycle multiply/divide stalls (with timeout abort). Holds the
//   pipeline flushed for RESET_HOLD cycles after reset release.
//   Ports:
//     clk    : clock, all state on rising edge
//     reset  : asynchronous active-low reset
//     hz     : hazard_ctrl_if.slave (hazard inputs, pipeline controls)
//     perf_stall_cycles / perf_flush_count : only with HAZARD_PERF_EN
//   Optional feature macro: HAZARD_PERF_EN (saturating performance counters).
module hazard_ctrl_unit #(
  parameter int RESET_HOLD  = 2,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [31:0]   perf_flush_count
`endif
);

  localparam int MAX_CNT = (RESET_HOLD > MUL_TIMEOUT) ? RESET_HOLD : MUL_TIMEOUT;
  localparam int CNT_W   = ($clog2(MAX_CNT + 1) > 8) ? $clog2(MAX_CNT + 1) : 8;

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MUL_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MUL_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic luse;
  logic pc_write, if_id_write, if_id_flush;
  logic id_ex_write, id_ex_flush, ex_mem_flush, mul_timeout;

  // rd==x0 never creates a dependency since x0 is hard-wired to zero
  assign luse = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                ((hz.if_id_use_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                 (hz.if_id_use_rs2 && (hz.if_id_rs2 == hz.id_ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mul_timeout  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz.branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hz.mul_start && !hz.mul_done) begin
          // Freeze front end and feed bubbles into MEM while the unit works
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          state_d      = ST_MUL_WAIT;
          cnt_d        = '0;
        end else if (hz.mul_start && hz.mul_done) begin
          // single-cycle completion: nothing to stall
        end else if (luse) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!hz.imem_ready) begin
          // Hold PC and send a bubble into ID; downstream keeps draining
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
        end
      end

      ST_MUL_WAIT: begin
        if (hz.mul_done) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          // Abort: drop the faulted op and let the pipeline resume
          mul_timeout  = 1'b1;
          ex_mem_flush = 1'b1;
          state_d      = ST_RUN;
          cnt_d        = '0;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_d        = cnt_q + 1'b1;
        end
      end

      default: begin
        // ST_INIT (and any illegal encoding): hold the pipeline flushed
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (state_q != ST_INIT) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_write  = id_ex_write;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.stall        = ~pc_write;
  assign hz.mul_timeout  = mul_timeout;

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!pc_write && (state_q != ST_INIT))
      perf_stall_d = sat_inc(perf_stall_q);
    if ((state_q == ST_RUN) && hz.branch_taken)
      perf_flush_d = sat_inc(perf_flush_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//   Directed bench for hazard_ctrl_unit (RESET_HOLD=2, MUL_TIMEOUT=8).
//   Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write,
//   id_ex_flush, ex_mem_flush, stall, mul_timeout}.
module tb_hazard_ctrl_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
  logic [31:0] snap;
`endif

  hazard_ctrl_unit #(
    .RESET_HOLD  (2),
    .MUL_TIMEOUT (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .hz                (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] RST  = 8'b0010_1110;
  localparam logic [7:0] DEF  = 8'b1101_0000;
  localparam logic [7:0] LUSE = 8'b0001_1010;
  localparam logic [7:0] BR   = 8'b1111_1000;
  localparam logic [7:0] MULS = 8'b0000_0110;
  localparam logic [7:0] IMEM = 8'b0111_0010;
  localparam logic [7:0] TMO  = 8'b1101_0101;

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic br, input logic imr, input logic ms, input logic md);
    hz.id_ex_mem_read = mr;
    hz.id_ex_rd       = rd;
    hz.if_id_rs1      = rs1;
    hz.if_id_rs2      = rs2;
    hz.if_id_use_rs1  = u1;
    hz.if_id_use_rs2  = u2;
    hz.branch_taken   = br;
    hz.imem_ready     = imr;
    hz.mul_start      = ms;
    hz.mul_done       = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic cmp_now(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
           hz.id_ex_flush, hz.ex_mem_flush, hz.stall, hz.mul_timeout};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    cmp_now(tag, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    reset = 1'b0;

    // reset held for 3 cycles
    chk("rst_c0", RST); next_cyc();
    chk("rst_c1", RST); next_cyc();
    chk("rst_c2", RST); next_cyc();
    reset = 1'b1;
    chk("init_c0", RST); next_cyc();
    chk("init_c1", RST); next_cyc();
    chk("run_first", DEF); next_cyc();

    // load-use via rs2, and the rd==x0 exemption
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("luse_rs2", LUSE); next_cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("luse_rd0_a", DEF); next_cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("luse_rd0_b", DEF); next_cyc();
    // load-use via rs1, then qualifiers removed
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("luse_rs1", LUSE); next_cyc();
    drive(1'b0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("luse_noload", DEF); next_cyc();
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("luse_nouse", DEF);
`ifdef HAZARD_PERF_EN
    snap = perf_flush_count;
`endif
    next_cyc();

    // branch beats load-use
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("br_luse", BR); next_cyc();
    idle();
    chk("br_after", DEF);
`ifdef HAZARD_PERF_EN
    chk32("perf_flush", perf_flush_count, snap + 32'd1);
`endif
    next_cyc();
    // branch beats mul_start and fetch wait; no MUL_WAIT entry
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("br_mul", BR); next_cyc();
    idle();
    chk("br_mul_after", DEF); next_cyc();

    // multi-cycle op, done on the 4th following cycle
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mul_start", MULS); next_cyc();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mul_w_br", MULS); next_cyc();
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mul_w_luse", MULS); next_cyc();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mul_w_imem", MULS); next_cyc();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mul_done", DEF); next_cyc();
    idle();
    chk("mul_run", DEF); next_cyc();

    // start and done together, with load-use present: no stall at all
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("mul_fast", DEF); next_cyc();
    idle();
    chk("mul_fast_run", DEF); next_cyc();

    // timeout: 8 MUL_WAIT cycles, pulse in the 8th
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tmo_start", MULS); next_cyc();
    idle();
    for (int i = 0; i < 7; i++) begin
      chk("tmo_wait", MULS); next_cyc();
    end
    chk("tmo_pulse", TMO); next_cyc();
    chk("tmo_run", DEF);
`ifdef HAZARD_PERF_EN
    snap = perf_stall_cycles;
`endif
    next_cyc();

    // fetch wait for 2 cycles
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("imem_c0", IMEM); next_cyc();
    chk("imem_c1", IMEM); next_cyc();
    idle();
    chk("imem_after", DEF);
`ifdef HAZARD_PERF_EN
    chk32("perf_stall", perf_stall_cycles, snap + 32'd2);
`endif
    next_cyc();

    // reset asserted mid MUL_WAIT takes effect immediately
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rw_start", MULS); next_cyc();
    idle();
    chk("rw_wait0", MULS); next_cyc();
    chk("rw_wait1", MULS);
    #2 reset = 1'b0;
    #1 cmp_now("rw_async", RST);
`ifdef HAZARD_PERF_EN
    chk32("perf_rst", perf_stall_cycles, 32'd0);
`endif
    next_cyc();
    chk("rw_held", RST); next_cyc();
    reset = 1'b1;
    chk("rw_init0", RST); next_cyc();
    chk("rw_init1", RST); next_cyc();
    chk("rw_run", DEF); next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
